// File: rtl/audio_pkg.sv
// Shared constants and the slot-to-word-select rule for the I2S transmitter.
package audio_pkg;

  localparam int unsigned SAMPLE_W  = 32;
  localparam int unsigned CH_W      = 16;
  localparam int unsigned SLOTS     = 32;
  localparam int unsigned SLOT_W    = $clog2(SLOTS);

  // lrck is high for slots LRCK_RISE..LRCK_FALL-1, leading each channel MSB by one slot.
  localparam int unsigned LRCK_RISE = 15;
  localparam int unsigned LRCK_FALL = 31;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  function automatic chan_e lrck_for_slot(input logic [SLOT_W-1:0] slot);
    if ((slot >= SLOT_W'(LRCK_RISE)) && (slot < SLOT_W'(LRCK_FALL))) begin
      return CH_RIGHT;
    end
    return CH_LEFT;
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample FIFO with registered occupancy count; head word is visible on dout.
module audio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         c,
  input  logic         rn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge c) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers stereo sample words and serialises them MSB first
// against a bit clock divided down from the system clock.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                c,
  input  logic                rn,
  input  logic [SAMPLE_W-1:0] x,
  input  logic                xv,
  output logic                xr,
  output logic                bclk,
  output logic                lrck,
  output logic                sd,
  output logic                underrun
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]       div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic                lrck_q, lrck_d;
  logic                sd_q, sd_d;
  logic                urun_q, urun_d;

  logic                tick;
  logic                fall_evt;
  logic                load;
  logic [SLOT_W-1:0]   slot_next;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  assign tick      = (div_q == DW'(DIV - 1));
  assign fall_evt  = tick && bclk_q;
  assign slot_next = slot_q + 1'b1;
  assign load      = fall_evt && (slot_next == '0);
  assign push      = xv && !fifo_full;
  assign pop       = load && !fifo_empty;

  audio_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .c     (c),
    .rn    (rn),
    .push  (push),
    .din   (x),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    bclk_d  = tick ? ~bclk_q : bclk_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    lrck_d  = lrck_q;
    sd_d    = sd_q;
    urun_d  = 1'b0;
    if (fall_evt) begin
      slot_d = slot_next;
      lrck_d = lrck_for_slot(slot_next);
      // fifo_empty is from the registered count, so a same-edge push cannot feed this load.
      if (load) begin
        shreg_d = fifo_empty ? '0 : fifo_head;
        sd_d    = fifo_empty ? 1'b0 : fifo_head[SAMPLE_W-1];
        urun_d  = fifo_empty;
      end else begin
        shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
        sd_d    = shreg_q[SAMPLE_W-2];
      end
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= '1;
      shreg_q <= '0;
      lrck_q  <= 1'b0;
      sd_q    <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      shreg_q <= shreg_d;
      lrck_q  <= lrck_d;
      sd_q    <= sd_d;
      urun_q  <= urun_d;
    end
  end

  assign xr       = !fifo_full;
  assign bclk     = bclk_q;
  assign lrck     = lrck_q;
  assign sd       = sd_q;
  assign underrun = urun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: one DIV=4 and one DIV=1 instance on a shared clock.
module tb_audio_i2s_tx;

  logic c = 1'b0;
  always #5 c = ~c;

  logic        rn4, xv4, xr4, bclk4, lrck4, sd4, ur4;
  logic [31:0] x4;
  logic        rn1, xv1, xr1, bclk1, lrck1, sd1, ur1;
  logic [31:0] x1;

  audio_i2s_tx #(.DIV(4), .DEPTH(4)) u_dut4 (
    .c(c), .rn(rn4), .x(x4), .xv(xv4), .xr(xr4),
    .bclk(bclk4), .lrck(lrck4), .sd(sd4), .underrun(ur4)
  );

  audio_i2s_tx #(.DIV(1), .DEPTH(4)) u_dut1 (
    .c(c), .rn(rn1), .x(x1), .xv(xv1), .xr(xr1),
    .bclk(bclk1), .lrck(lrck1), .sd(sd1), .underrun(ur1)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] words [6];
  logic [31:0] cap   [3];
  int          acc_edge [6];
  int          ur_edge  [4];
  int          n_acc, n_ur, sd_hi, lrck_tr, slot, fr, k;
  logic        acc, prev_lrck;
  logic [31:0] pat, cw, m0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    words[0] = 32'h1111_2222; words[1] = 32'h3333_4444; words[2] = 32'h8000_0001;
    words[3] = 32'h7FFF_FFFE; words[4] = 32'hDEAD_BEEF; words[5] = 32'hCAFE_F00D;
    rn4 = 1'b0; xv4 = 1'b0; x4 = '0;
    rn1 = 1'b0; xv1 = 1'b0; x1 = '0;

    // Reset hold (DIV=4): {bclk,lrck,sd,underrun,xr} = 00001
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      check("reset_outs", {27'b0, bclk4, lrck4, sd4, ur4, xr4}, 32'h1);
    end

    // Backpressure and ordering (DIV=4), xv held high from release
    rn4 = 1'b1; xv4 = 1'b1; x4 = words[0]; n_acc = 0;
    for (int e = 1; e <= 776; e++) begin
      acc = xv4 && xr4;
      @(negedge c);
      if (acc) begin
        if (n_acc < 6) acc_edge[n_acc] = e;
        n_acc++;
        if (n_acc < 6) x4 = words[n_acc];
        else xv4 = 1'b0;
      end
      if (e <= 8) check($sformatf("bclk_first e=%0d", e), bclk4, (e >= 4 && e < 8));
      if (e == 4) check("xr_full_after_4", xr4, 1'b0);
      if (e == 7) check("xr_full_before_load", xr4, 1'b0);
      if (e == 8) check("xr_rise_after_load", xr4, 1'b1);
      if (e == 9) check("xr_full_again", xr4, 1'b0);
      if (e == 8) check("bp_no_underrun_load0", ur4, 1'b0);
      if (e >= 8 && (e - 8) % 8 == 0) begin
        slot = ((e - 8) / 8) % 32;
        fr   = (e - 8) / 256;
        if (fr < 3) cap[fr][31 - slot] = sd4;
      end
    end
    check("bp_accept_count", n_acc, 6);
    check("bp_acc0", acc_edge[0], 1);
    check("bp_acc3", acc_edge[3], 4);
    check("bp_acc4", acc_edge[4], 9);
    check("bp_acc5", acc_edge[5], 265);
    check("bp_word0", cap[0], words[0]);
    check("bp_word1", cap[1], words[1]);
    check("bp_word2", cap[2], words[2]);

    // Underrun every frame (DIV=4), no pushes
    @(negedge c); rn4 = 1'b0; xv4 = 1'b0;
    #1 check("underrun_reset_outs", {27'b0, bclk4, lrck4, sd4, ur4, xr4}, 32'h1);
    @(negedge c); rn4 = 1'b1;
    n_ur = 0; sd_hi = 0; lrck_tr = 0; prev_lrck = 1'b0;
    for (int e = 1; e <= 530; e++) begin
      @(negedge c);
      if (ur4) begin
        if (n_ur < 4) ur_edge[n_ur] = e;
        n_ur++;
      end
      if (sd4) sd_hi++;
      if (lrck4 !== prev_lrck) lrck_tr++;
      prev_lrck = lrck4;
    end
    check("ur_count", n_ur, 3);
    check("ur_edge0", ur_edge[0], 8);
    check("ur_edge1", ur_edge[1], 264);
    check("ur_edge2", ur_edge[2], 520);
    check("ur_sd_zero", sd_hi, 0);
    check("ur_lrck_toggles", lrck_tr, 4);
    rn4 = 1'b0;

    // Bit order (DIV=1)
    @(negedge c);
    rn1 = 1'b1; xv1 = 1'b1; x1 = 32'hA5A5_0F0F; pat = 32'hA5A5_0F0F;
    for (int e = 1; e <= 67; e++) begin
      @(negedge c);
      if (e == 1) begin
        xv1 = 1'b0;
        check("d1_first_rise", bclk1, 1'b1);
        check("d1_xr", xr1, 1'b1);
      end
      if (e >= 2 && e <= 65) begin
        k = (e - 2) / 2;
        check($sformatf("bit_order e=%0d", e),
              {28'b0, bclk1, lrck1, sd1, ur1},
              {28'b0, 1'(e % 2), 1'(k >= 15 && k <= 30), pat[31 - k], 1'b0});
      end
      if (e == 66) check("d1_frame2_underrun", {30'b0, sd1, ur1}, 32'h1);
      if (e == 67) check("d1_underrun_one_cycle", ur1, 1'b0);
    end

    // Push/load collision (DIV=1)
    rn1 = 1'b0; @(negedge c); @(negedge c);
    rn1 = 1'b1; cw = 32'h9C3A_5E71;
    cap[0] = 32'hFFFF_FFFF; cap[1] = '0;
    for (int e = 1; e <= 133; e++) begin
      @(negedge c);
      if (e == 1) begin xv1 = 1'b1; x1 = cw; end
      if (e == 2) begin
        xv1 = 1'b0;
        check("collision_underrun", ur1, 1'b1);
      end
      if (e == 66) check("collision_next_load_ok", ur1, 1'b0);
      if (e >= 2 && e <= 129 && (e % 2) == 0) begin
        k  = ((e - 2) / 2) % 32;
        fr = (e - 2) / 64;
        cap[fr][31 - k] = sd1;
      end
    end
    check("collision_frame0", cap[0], 32'h0);
    check("collision_frame1", cap[1], cw);

    // Mid-frame asynchronous reset (DIV=1), two words queued
    rn1 = 1'b0; @(negedge c); @(negedge c);
    m0 = 32'h1234_5F78;
    rn1 = 1'b1; xv1 = 1'b1; x1 = m0;
    for (int e = 1; e <= 43; e++) begin
      @(negedge c);
      if (e == 1) x1 = 32'h0BAD_F00D;
      if (e == 2) x1 = 32'h7777_1111;
      if (e == 3) xv1 = 1'b0;
    end
    check("pre_reset_slot20", {27'b0, bclk1, lrck1, sd1, ur1, xr1}, {27'b0, 1'b1, 1'b1, m0[11], 1'b0, 1'b1});
    rn1 = 1'b0;
    #1 check("async_reset_outs", {27'b0, bclk1, lrck1, sd1, ur1, xr1}, 32'h1);
    @(negedge c);
    check("reset_hold_outs", {27'b0, bclk1, lrck1, sd1, ur1, xr1}, 32'h1);
    rn1 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge c);
      if (e == 2) check("post_reset_underrun", {30'b0, sd1, ur1}, 32'h1);
      if (e == 3) check("post_reset_ur_clear", ur1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter: downstream of the audio sample source. Accepts 32-bit stereo sample words (left in the upper half, right in the lower half) through a valid/ready handshake. Buffers them in a small FIFO and shifts them out as an I2S stream (bit clock, word select, serial data) to the off-chip DAC. All logic runs on the single system clock; the bit clock is a divided, registered output.

## Interface
Parameters:
- DIV, default 4: system clock cycles per bit-clock half period; legal range is DIV ≥ 1.
- DEPTH, default 4: FIFO depth in sample words; must be a power of 2 and at least 2.

Ports:
- c  in  1: system clock; all state changes on the rising edge.
- rn  in  1: asynchronous, active-low reset; deassertion is synchronous to c.
- x  in  32: sample word; x[31:16] is left, x[15:0] is right, both two's complement.
- xv  in  1: x is valid.
- xr  out  1: ready; equals 1 when the FIFO is not full.
- bclk  out  1: I2S bit clock.
- lrck  out  1: I2S word select; 0 = left, 1 = right.
- sd  out  1: I2S serial data, MSB first.
- underrun  out  1: one-cycle pulse; a frame started while the FIFO was empty.

## Operation
- **Push:** when xv && xr is high on a c edge, x is written to the FIFO. xr is derived only from the registered count, never from xv.
- **Divider:** counter d runs 0..DIV-1. When d == DIV-1, d wraps to 0 and bclk toggles.
  - A 1→0 toggle is a falling event. On that same c edge the slot counter b advances modulo 32.
  - sd and lrck update only on falling events, so they are stable while bclk is high.
- **Slot mapping:** on entering slot k, sd is set to word bit (31-k).
  - Slots 0..15 carry the left channel, MSB first.
  - Slots 16..31 carry the right channel, MSB first.
- **Word select:** lrck is 1 for slots 15..30 and 0 for slots 31 and 0..14. It therefore leads each channel MSB by one slot, which is the I2S one-bit delay.
- **Load:** on the falling event that enters slot 0, the FIFO head is popped into a 32-bit shift register. The slot-0 sd value is bit 31 of that word.
- **Underrun:** if the FIFO is empty at a load, the word is 0, underrun pulses high for exactly that one c cycle, and bclk/lrck continue unchanged.
- **No bypass:** a push into an empty FIFO on the same edge as a load does not count for that load. That load underruns, and the pushed word is sent in the next frame.
- **Full FIFO at load:** xr is 0 on the load edge, so no push occurs. xr rises on the following cycle.

## Timing
- **Reset values:** bclk=0, lrck=0, sd=0, underrun=0, xr=1, d=0, b=31, FIFO empty, shift register 0.
- After rn rises:
  - First toggle (bclk 0→1) occurs on the DIV-th c edge.
  - First falling event, which enters slot 0 and performs a load, occurs on edge 2·DIV.
- bclk period is 2·DIV c cycles; a frame is 64·DIV c cycles; sample rate is f_c/(64·DIV).
- **Latency:** a word pushed at least one cycle before a load appears as sd for slot 0 of that frame.
- **Handshake:** xr drops on the edge after the push that fills the FIFO.
- **Reset mid-frame:** rn low returns every output to its reset value immediately (asynchronously). The FIFO and the partial frame are discarded.

## Structure
- Package audio_pkg holds:
  - SAMPLE_W=32, CH_W=16, SLOTS=32.
  - The slot-to-lrck rule, expressed as constants LRCK_RISE=15 and LRCK_FALL=31.
- Sub-module audio_fifo(c, rn, push, din, pop, dout, full, empty) is a DEPTH-parametrised synchronous FIFO with registered count.
- The top level contains the divider, slot counter, shift register and output registers.

## Test plan
- **Reset:** hold rn low for 3 cycles → bclk=lrck=sd=underrun=0 and xr=1 throughout; first bclk rise after 4 c edges (DIV=4).
- **Bit order (DIV=1):** push 0xA5A5_0F0F right after reset → sd over slots 0..31 = 1010010110100101 0000111100001111; lrck=1 exactly in slots 15..30; bclk period 2 cycles; no underrun.
- **Backpressure:** hold xv=1 with distinct words from reset → 4 words accepted and xr=0; the 5th is accepted on the cycle after the first load; words emerge in order.
- **Underrun:** no pushes → underrun pulses once per frame (every 64·DIV cycles) at each slot-0 entry; sd=0 and lrck still toggles.
- **Push/load collision:** push into an empty FIFO on the exact slot-0 load edge → underrun=1 in that frame; the word is transmitted in the next frame.
- **Mid-frame reset:** assert rn in slot 20 with 2 words queued → outputs return to reset values within the same cycle; after release, the FIFO is empty and the first frame underruns.
